// File: rtl/spi_regbank_pkg.sv
// Shared FSM state type and frame-layout helpers for the SPI register bank.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    COMMIT
  } state_t;

  // The W flag sits this many bit positions below the frame MSB.
  localparam int W_BIT_FROM_MSB = 0;

  function automatic int frame_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus history flop; rise/fall pulse one clk, two clk after the input edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/spi_regbank.sv
// SPI target register bank: oversampled SPI frames write/read a parametrised register file.
// Writes land 4 clk after raw cs rise; no backpressure, malformed frames pulse frame_err.
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int   NUM_REGS = 5,
  parameter int   DATA_W   = 8,
  parameter int   ADDR_W   = 7,
  parameter logic CPOL     = 1'b0,
  parameter logic CPHA     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       sdi,
  input  logic                       cs,
  output logic                       sdo,
  output logic [NUM_REGS*DATA_W-1:0] regs,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int W_POS   = FRAME_W - 1 - W_BIT_FROM_MSB;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_HDR  = CNT_W'(ADDR_W);
  localparam logic [ADDR_W:0]   NREGS    = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic sdi_meta, sdi_s;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdi_meta <= 1'b0;
      sdi_s    <= 1'b0;
    end else begin
      sdi_meta <= sdi;
      sdi_s    <= sdi_meta;
    end
  end

  logic lead_edge, trail_edge, sample_edge, shift_edge;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [FRAME_W-1:0]  rx;
  logic [DATA_W-1:0]   tx;
  logic                tx_vld;
  logic                load_pend;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  // Full-frame fields are valid in COMMIT; header fields once 1+ADDR_W bits are in.
  logic               w_bit, hdr_w, addr_ok;
  logic [ADDR_W-1:0]  addr_f, hdr_addr;
  logic [DATA_W-1:0]  data_f, rd_val;

  assign w_bit    = rx[W_POS];
  assign addr_f   = rx[W_POS-1 -: ADDR_W];
  assign data_f   = rx[DATA_W-1:0];
  assign hdr_w    = rx[ADDR_W];
  assign hdr_addr = rx[ADDR_W-1:0];
  assign addr_ok  = ({1'b0, addr_f} < NREGS);

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_W'(i)) rd_val = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      tx_vld    <= 1'b0;
      load_pend <= 1'b0;
      sdo       <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          sdo <= 1'b0;
          if (cs_fall) begin
            state     <= ACTIVE;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            tx_vld    <= 1'b0;
            load_pend <= 1'b0;
          end
        end
        ACTIVE: begin
          load_pend <= 1'b0;
          if (sample_edge) begin
            rx <= {rx[FRAME_W-2:0], sdi_s};
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            load_pend <= (cnt == CNT_HDR);
          end
          // Header just completed: a read fetches its register before the data phase.
          if (load_pend && !hdr_w) begin
            tx     <= rd_val;
            tx_vld <= 1'b1;
          end else if (shift_edge && tx_vld) begin
            sdo <= tx[DATA_W-1];
            tx  <= tx << 1;
          end
          if (cs_rise) state <= COMMIT;
        end
        COMMIT: begin
          sdo    <= 1'b0;
          tx_vld <= 1'b0;
          state  <= IDLE;
          if (cnt == CNT_FULL && w_bit && addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr_f == ADDR_W'(i)) regs_q[i] <= data_f;
            end
            wr_strobe <= 1'b1;
            wr_addr   <= addr_f;
          end else if (!(cnt == CNT_FULL && !w_bit)) begin
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule
